// File: rtl/hdmi_text_pkg.sv
// hdmi_text_pkg
// Shared constants and types for the HDMI text controller.
//   - 640x480 @ 60 Hz video timing (25 MHz pixel clock)
//   - register file geometry: 600 VRAM words plus one control word
//   - rgb_t: packed 4-bit-per-channel color
package hdmi_text_pkg;

    // Horizontal timing, in pixel clocks
    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FP     = 10'd16;
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_TOTAL  = 10'd800;

    // Vertical timing, in lines
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FP     = 10'd10;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_TOTAL  = 10'd525;

    // Register file: words 0..599 hold 80x30 characters (4 per word), word 600 is control
    localparam int         NUM_REGS = 601;
    localparam logic [9:0] CTRL_IDX = 10'd600;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

endpackage

// File: rtl/font_rom.sv
// font_rom
// 2048 x 8 combinational glyph ROM: 128 glyphs of 8x16 pixels, bit 7 is the
// leftmost pixel of a row.
//   addr [10:0] in  : {glyph code[6:0], glyph row[3:0]}
//   data [7:0]  out : pixel row, bit 7 leftmost
// The glyph set is procedural rather than a bitmap font: codes 0x00 and 0x20
// are blank, every other glyph has blank top and bottom rows and rows 1..14
// equal to {1, code}. This keeps every glyph distinct and easy to predict.
module font_rom (
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    logic [6:0] code;
    logic [3:0] row;

    assign code = addr[10:4];
    assign row  = addr[3:0];

    always_comb begin
        data = 8'h00;
        if ((code != 7'h00) && (code != 7'h20) && (row != 4'h0) && (row != 4'hF)) begin
            data = {1'b1, code};
        end
    end

endmodule

// File: rtl/hdmi_text_controller.sv
// hdmi_text_controller
// AXI4-Lite slave holding an 80x30 character VRAM plus a color control word,
// and a 640x480 text-mode video generator rendering straight from that VRAM.
//   pixel_clk, arstn (sync, active-low)  : shared AXI / video clock and reset
//   axi_aw*/axi_w*/axi_b*                : AXI4-Lite write address/data/response
//   axi_ar*/axi_r*                       : AXI4-Lite read address/data
//   drawX, drawY                         : current pixel column / row
//   hsync, vsync (active-low), vde       : video sync and active-video enable
//   red, green, blue                     : 4-bit pixel color
module hdmi_text_controller
    import hdmi_text_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 16
) (
    input  logic                          pixel_clk,
    input  logic                          arstn,

    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [2:0]                    axi_awprot,
    input  logic                          axi_awvalid,
    output logic                          axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                          axi_wvalid,
    output logic                          axi_wready,
    output logic [1:0]                    axi_bresp,
    output logic                          axi_bvalid,
    input  logic                          axi_bready,

    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [2:0]                    axi_arprot,
    input  logic                          axi_arvalid,
    output logic                          axi_arready,
    output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]                    axi_rresp,
    output logic                          axi_rvalid,
    input  logic                          axi_rready,

    output logic [9:0]                    drawX,
    output logic [9:0]                    drawY,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          vde,
    output logic [3:0]                    red,
    output logic [3:0]                    green,
    output logic [3:0]                    blue
);

    logic [C_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [9:0]                  hc;
    logic [9:0]                  vc;

    // Any address bit above the 4 KB window makes the access out of range,
    // so aliases such as 0x1000 never reach word 0.
    logic [9:0] wr_idx;
    logic [9:0] rd_idx;
    logic       wr_in_range;
    logic       rd_in_range;

    assign wr_idx      = axi_awaddr[11:2];
    assign rd_idx      = axi_araddr[11:2];
    assign wr_in_range = (axi_awaddr[C_AXI_ADDR_WIDTH-1:12] == '0) && (wr_idx <= CTRL_IDX);
    assign rd_in_range = (axi_araddr[C_AXI_ADDR_WIDTH-1:12] == '0) && (rd_idx <= CTRL_IDX);

    assign axi_bresp = 2'b00;
    assign axi_rresp = 2'b00;

    // AXI slave. The ready pulses are registered, so a handshake completes on
    // the edge after the request is seen; the write and the read capture share
    // that edge, giving read-before-write ordering on a collision.
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b0;
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rdata   <= '0;
        end else begin
            axi_awready <= axi_awvalid && axi_wvalid && !axi_bvalid && !axi_awready;
            axi_wready  <= axi_awvalid && axi_wvalid && !axi_bvalid && !axi_awready;
            if (axi_awready && axi_awvalid && axi_wvalid) begin
                axi_bvalid <= 1'b1;
                if (wr_in_range) begin
                    for (int k = 0; k < C_AXI_DATA_WIDTH/8; k++) begin
                        if (axi_wstrb[k]) begin
                            regs[wr_idx][8*k +: 8] <= axi_wdata[8*k +: 8];
                        end
                    end
                end
            end else if (axi_bvalid && axi_bready) begin
                axi_bvalid <= 1'b0;
            end

            axi_arready <= axi_arvalid && !axi_rvalid && !axi_arready;
            if (axi_arready && axi_arvalid) begin
                axi_rvalid <= 1'b1;
                axi_rdata  <= rd_in_range ? regs[rd_idx] : '0;
            end else if (axi_rvalid && axi_rready) begin
                axi_rvalid <= 1'b0;
            end
        end
    end

    // Free-running raster counters; the line counter advances on column wrap.
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_TOTAL - 10'd1) begin
            hc <= '0;
            vc <= (vc == V_TOTAL - 10'd1) ? 10'd0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    assign drawX = hc;
    assign drawY = vc;
    assign hsync = !((hc >= H_ACTIVE + H_FP) && (hc < H_ACTIVE + H_FP + H_SYNC));
    assign vsync = !((vc >= V_ACTIVE + V_FP) && (vc < V_ACTIVE + V_FP + V_SYNC));
    assign vde   = (hc < H_ACTIVE) && (vc < V_ACTIVE);

    logic [6:0]                  col;
    logic [4:0]                  row;
    logic [9:0]                  vram_idx;
    logic [C_AXI_DATA_WIDTH-1:0] vram_word;
    logic [7:0]                  char_byte;
    logic [10:0]                 font_addr;
    logic [7:0]                  font_data;
    logic                        pix_on;
    logic [C_AXI_DATA_WIDTH-1:0] ctrl;
    rgb_t                        fg;
    rgb_t                        bg;
    rgb_t                        pix;

    font_rom u_font_rom (
        .addr (font_addr),
        .data (font_data)
    );

    // Renderer reads VRAM and control combinationally, so a write is visible
    // on the very next pixel. row*20 is built from shifts (16 + 4).
    always_comb begin
        col       = hc[9:3];
        row       = vc[8:4];
        vram_idx  = 10'({row, 4'b0000}) + 10'({row, 2'b00}) + 10'(col[6:2]);
        vram_word = (vde && (vram_idx < CTRL_IDX)) ? regs[vram_idx] : '0;
        case (col[1:0])
            2'd0:    char_byte = vram_word[7:0];
            2'd1:    char_byte = vram_word[15:8];
            2'd2:    char_byte = vram_word[23:16];
            default: char_byte = vram_word[31:24];
        endcase
        font_addr = {char_byte[6:0], vc[3:0]};
        pix_on    = font_data[~hc[2:0]] ^ char_byte[7];
        ctrl      = regs[CTRL_IDX];
        fg        = '{r: ctrl[24:21], g: ctrl[20:17], b: ctrl[16:13]};
        bg        = '{r: ctrl[12:9],  g: ctrl[8:5],   b: ctrl[4:1]};
        pix       = '0;
        if (vde) begin
            pix = pix_on ? fg : bg;
        end
    end

    assign red   = pix.r;
    assign green = pix.g;
    assign blue  = pix.b;

    // Inputs and control bits that carry no function are collected here.
    logic unused_bits;
    assign unused_bits = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0],
                           ctrl[C_AXI_DATA_WIDTH-1:25], ctrl[0]};

endmodule

// File: tb/tb_hdmi_text_controller.sv
// tb_hdmi_text_controller
// Self-checking bench for hdmi_text_controller: reset values, raster timing
// against an independent counter model, glyph rendering, table-driven AXI
// register vectors, a full VRAM sweep and multi-cycle AXI corner cases.
module tb_hdmi_text_controller;

    logic        pixel_clk = 1'b0;
    logic        arstn     = 1'b0;
    logic [15:0] axi_awaddr = '0;
    logic [2:0]  axi_awprot = '0;
    logic        axi_awvalid = 1'b0;
    logic        axi_awready;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wstrb = '0;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready = 1'b0;
    logic [15:0] axi_araddr = '0;
    logic [2:0]  axi_arprot = '0;
    logic        axi_arvalid = 1'b0;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready = 1'b0;
    logic [9:0]  drawX;
    logic [9:0]  drawY;
    logic        hsync;
    logic        vsync;
    logic        vde;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    hdmi_text_controller #(
        .C_AXI_DATA_WIDTH (32),
        .C_AXI_ADDR_WIDTH (16)
    ) dut (
        .pixel_clk   (pixel_clk),
        .arstn       (arstn),
        .axi_awaddr  (axi_awaddr),
        .axi_awprot  (axi_awprot),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_araddr  (axi_araddr),
        .axi_arprot  (axi_arprot),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .drawX       (drawX),
        .drawY       (drawY),
        .hsync       (hsync),
        .vsync       (vsync),
        .vde         (vde),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        axi_awaddr  = addr;
        axi_wdata   = data;
        axi_wstrb   = strb;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        n = 0;
        tick();
        while (!axi_awready && n < 20) begin
            tick();
            n++;
        end
        if (!axi_awready) begin
            reportTimeout("write_awready");
            axi_awvalid = 1'b0;
            axi_wvalid  = 1'b0;
            return;
        end
        checkOutput("write_wready", 32'(axi_wready), 32'd1);
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        checkOutput("write_bvalid", 32'(axi_bvalid), 32'd1);
        checkOutput("write_bresp", 32'(axi_bresp), 32'd0);
        checkOutput("write_awready_drop", 32'(axi_awready), 32'd0);
        axi_bready = 1'b1;
        tick();
        axi_bready = 1'b0;
        checkOutput("write_bvalid_clear", 32'(axi_bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [15:0] addr, output logic [31:0] data);
        int n;
        data        = '0;
        axi_araddr  = addr;
        axi_arvalid = 1'b1;
        n = 0;
        tick();
        while (!axi_arready && n < 20) begin
            tick();
            n++;
        end
        if (!axi_arready) begin
            reportTimeout("read_arready");
            axi_arvalid = 1'b0;
            return;
        end
        tick();
        axi_arvalid = 1'b0;
        checkOutput("read_rvalid", 32'(axi_rvalid), 32'd1);
        checkOutput("read_rresp", 32'(axi_rresp), 32'd0);
        data = axi_rdata;
        axi_rready = 1'b1;
        tick();
        axi_rready = 1'b0;
        checkOutput("read_rvalid_clear", 32'(axi_rvalid), 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [31:0] rd;
        axi_write(v.addr, v.wdata, v.wstrb);
        axi_read(v.addr, rd);
        checkOutput($sformatf("table%0d_rdata", idx), rd, v.exp_rdata);
    endtask

    task automatic wait_pixel(input logic [9:0] x, input logic [9:0] y);
        int n;
        n = 0;
        while (!(drawX == x && drawY == y) && n < 12000) begin
            tick();
            n++;
        end
        if (!(drawX == x && drawY == y)) reportTimeout("wait_pixel");
    endtask

    initial begin
        logic [31:0] rd;
        logic [11:0] exp_row1 [9];
        logic [11:0] exp_row3 [3];
        int m_hc;
        int m_vc;
        int timing_bad;
        int hs_low;
        int de_high;
        logic exp_hs;
        logic exp_vs;
        logic exp_de;

        vecs[0] = '{16'h0960, 32'h001F6000, 4'b1111, 32'h001F6000};
        vecs[1] = '{16'h0000, 32'hFFFFFFFF, 4'b1111, 32'hFFFFFFFF};
        vecs[2] = '{16'h0000, 32'h00000012, 4'b0001, 32'hFFFFFF12};
        vecs[3] = '{16'h1000, 32'h12345678, 4'b1111, 32'h00000000};
        vecs[4] = '{16'h0964, 32'h0000AAAA, 4'b1111, 32'h00000000};
        vecs[5] = '{16'h095C, 32'hDEADBEEF, 4'b1010, 32'hDE00BE00};
        vecs[6] = '{16'h0004, 32'h11223344, 4'b0110, 32'h00223300};

        // Reset state
        arstn = 1'b0;
        repeat (4) tick();
        checkOutput("rst_awready", 32'(axi_awready), 32'd0);
        checkOutput("rst_wready", 32'(axi_wready), 32'd0);
        checkOutput("rst_bvalid", 32'(axi_bvalid), 32'd0);
        checkOutput("rst_arready", 32'(axi_arready), 32'd0);
        checkOutput("rst_rvalid", 32'(axi_rvalid), 32'd0);
        checkOutput("rst_rdata", axi_rdata, 32'd0);
        checkOutput("rst_bresp", 32'(axi_bresp), 32'd0);
        checkOutput("rst_rresp", 32'(axi_rresp), 32'd0);
        checkOutput("rst_drawX", 32'(drawX), 32'd0);
        checkOutput("rst_drawY", 32'(drawY), 32'd0);
        checkOutput("rst_hsync", 32'(hsync), 32'd1);
        checkOutput("rst_vsync", 32'(vsync), 32'd1);

        // Raster timing over two lines against an independent counter model
        arstn = 1'b1;
        m_hc = 0;
        m_vc = 0;
        timing_bad = 0;
        hs_low = 0;
        de_high = 0;
        for (int c = 0; c < 1600; c++) begin
            exp_hs = !(m_hc >= 656 && m_hc < 752);
            exp_vs = !(m_vc >= 490 && m_vc < 492);
            exp_de = (m_hc < 640) && (m_vc < 480);
            if (drawX != 10'(m_hc) || drawY != 10'(m_vc) || hsync != exp_hs ||
                vsync != exp_vs || vde != exp_de || (!exp_de && {red, green, blue} != 12'h000)) begin
                timing_bad++;
            end
            if (!hsync) hs_low++;
            if (vde) de_high++;
            tick();
            m_hc++;
            if (m_hc == 800) begin
                m_hc = 0;
                m_vc++;
            end
        end
        checkOutput("timing_model_mismatches", 32'(timing_bad), 32'd0);
        checkOutput("hsync_low_two_lines", 32'(hs_low), 32'd192);
        checkOutput("vde_high_two_lines", 32'(de_high), 32'd1280);
        checkOutput("drawY_after_two_lines", 32'(drawY), 32'd2);

        // Rendering: inverted glyph 0x41 in cell (0,0), fg (0,F,B), bg black
        arstn = 1'b0;
        repeat (2) tick();
        arstn = 1'b1;
        axi_write(16'h0000, 32'h000000C1, 4'b1111);
        axi_write(16'h0960, 32'h001F6000, 4'b1111);
        exp_row1 = '{12'h000, 12'h000, 12'h0FB, 12'h0FB, 12'h0FB, 12'h0FB, 12'h0FB, 12'h000, 12'h000};
        wait_pixel(10'd0, 10'd1);
        for (int x = 0; x < 9; x++) begin
            checkOutput($sformatf("row1_px%0d", x), 32'({red, green, blue}), 32'(exp_row1[x]));
            tick();
        end
        wait_pixel(10'd640, 10'd1);
        checkOutput("blank_vde", 32'(vde), 32'd0);
        checkOutput("blank_rgb", 32'({red, green, blue}), 32'd0);

        // Control change shows on the next rendered pixels
        axi_write(16'h0960, 32'h01E00000, 4'b1111);
        exp_row3 = '{12'h000, 12'h000, 12'hF00};
        wait_pixel(10'd0, 10'd3);
        for (int x = 0; x < 3; x++) begin
            checkOutput($sformatf("row3_px%0d", x), 32'({red, green, blue}), 32'(exp_row3[x]));
            tick();
        end

        // Table-driven register vectors
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Full VRAM sweep
        for (int i = 0; i < 600; i++) begin
            axi_write(16'(i * 4), 32'(i), 4'b1111);
        end
        for (int i = 0; i < 600; i++) begin
            axi_read(16'(i * 4), rd);
            checkOutput($sformatf("sweep_word%0d", i), rd, 32'(i));
        end

        // Simultaneous read and write of word 5 returns the old value
        axi_awaddr  = 16'h0014;
        axi_wdata   = 32'h0000ABCD;
        axi_wstrb   = 4'b1111;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        axi_araddr  = 16'h0014;
        axi_arvalid = 1'b1;
        tick();
        checkOutput("rw_awready", 32'(axi_awready), 32'd1);
        checkOutput("rw_arready", 32'(axi_arready), 32'd1);
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_arvalid = 1'b0;
        checkOutput("rw_rvalid", 32'(axi_rvalid), 32'd1);
        checkOutput("rw_rdata_old", axi_rdata, 32'd5);
        checkOutput("rw_bvalid", 32'(axi_bvalid), 32'd1);
        axi_rready = 1'b1;
        axi_bready = 1'b1;
        tick();
        axi_rready = 1'b0;
        axi_bready = 1'b0;
        axi_read(16'h0014, rd);
        checkOutput("rw_rdata_new", rd, 32'h0000ABCD);

        // Reset during a write handshake aborts it with no response
        axi_awaddr  = 16'h0008;
        axi_wdata   = 32'h00000077;
        axi_wstrb   = 4'b1111;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        tick();
        checkOutput("abort_awready", 32'(axi_awready), 32'd1);
        arstn = 1'b0;
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        checkOutput("abort_awready_rst", 32'(axi_awready), 32'd0);
        checkOutput("abort_bvalid_rst", 32'(axi_bvalid), 32'd0);
        arstn = 1'b1;
        repeat (3) tick();
        checkOutput("abort_bvalid_after", 32'(axi_bvalid), 32'd0);
        axi_read(16'h0008, rd);
        checkOutput("abort_word2", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdmi_text_controller.md
HDMI_TEXT_CONTROLLER -- requirements
Module: hdmi_text_controller

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 16, AXI byte-address width.
REQ-003 pixel_clk  in  1  single clock for AXI and video, 25 MHz.
REQ-004 arstn  in  1  reset, synchronous, active-low.
REQ-005 axi_awaddr in ADDR, axi_awprot in 3 (ignored), axi_awvalid in 1, axi_awready out 1  write address channel.
REQ-006 axi_wdata in 32, axi_wstrb in 4, axi_wvalid in 1, axi_wready out 1  write data channel.
REQ-007 axi_bresp out 2, axi_bvalid out 1, axi_bready in 1  write response channel.
REQ-008 axi_araddr in ADDR, axi_arprot in 3 (ignored), axi_arvalid in 1, axi_arready out 1  read address channel.
REQ-009 axi_rdata out 32, axi_rresp out 2, axi_rvalid out 1, axi_rready in 1  read data channel.
REQ-010 drawX out 10, drawY out 10  current pixel column/row counters.
REQ-011 hsync out 1, vsync out 1 (active-low), vde out 1 (active-video enable).
REQ-012 red out 4, green out 4, blue out 4  pixel color.

Function
REQ-013 Register file: 601 x 32-bit words; word index = addr[11:2]; words 0..599 VRAM, word 600 (byte 0x960) control.
REQ-014 Write: when awvalid & wvalid & !bvalid, assert awready and wready together for exactly one cycle and update the word, byte lane k written iff wstrb[k].
REQ-015 bvalid SHALL rise the cycle after the write handshake, bresp = 2'b00, held until bready sampled high, then cleared.
REQ-016 Read: when arvalid & !rvalid, assert arready one cycle; next cycle rvalid = 1, rdata = addressed word, rresp = 2'b00; held until rready high.
REQ-017 Index > 600: writes discarded, reads return 0, response still OKAY.
REQ-018 Same-cycle read and write of one word: read returns pre-write value.
REQ-019 Timing: hc counts 0..799, vc counts 0..524 (vc increments when hc wraps); drawX = hc, drawY = vc.
REQ-020 hsync = 0 for hc 656..751; vsync = 0 for vc 490..491; vde = (hc < 640) & (vc < 480).
REQ-021 Text grid 80x30 cells of 8x16 px: col = hc[9:3], row = vc[8:4]; char byte = byte (col mod 4) of VRAM word (row*20 + col/4).
REQ-022 Char byte: bit7 = invert, bits6:0 = glyph code; font address = {code, vc[3:0]} (11 bits), font bit (7 - hc[2:0]) = pixel.
REQ-023 Control: fg R/G/B = ctrl[24:21]/[20:17]/[16:13]; bg R/G/B = ctrl[12:9]/[8:5]/[4:1]; other bits stored, unused.
REQ-024 Pixel on = font bit XOR invert; RGB = fg if on else bg, when vde; RGB = 0 when !vde.
REQ-025 drawX, drawY, sync, vde and RGB SHALL be combinationally consistent (all describe the same pixel in the same cycle).
REQ-026 VRAM/control writes SHALL affect the very next rendered pixel (no frame buffering).

Reset
REQ-027 While arstn = 0 at a pixel_clk edge: all 601 words = 0, hc = vc = 0, awready/wready/bvalid/arready/rvalid = 0, rdata = 0.
REQ-028 Reset mid-transaction SHALL abort it; no response issued afterward.

Structure
REQ-029 Shared package hdmi_text_pkg: H/V active, front porch, sync, total constants; NUM_REGS = 601; CTRL_IDX = 600.
REQ-030 Sub-module font_rom: 2048 x 8 combinational ROM, 128 glyphs, 8x16, bit 7 leftmost; top contains AXI, timing and render logic.

Verification
REQ-031 Reset 4 cycles -> all AXI outputs 0, drawX = drawY = 0, hsync = vsync = 1.
REQ-032 Write 0x960 <- 0x001F6000, read 0x960 -> 0x001F6000, bresp = rresp = 0.
REQ-033 Write word i <- i for i = 0..599, read all back -> each equals i.
REQ-034 Write 0x0 <- 0xFFFFFFFF then 0x0 <- 0x00000012 with wstrb = 4'b0001 -> read 0xFFFFFF12; read 0x1000 -> 0.
REQ-035 Free-run -> hsync low exactly 96 of 800 cycles per line, vsync low 2 lines of 525, vde high 640x480 per frame.
REQ-036 Word 0 <- 0x000000C1, ctrl 0x001F6000 -> cell (0,0) shows glyph 0x41 inverted, fg = (0,F,B), bg = (0,0,0).
